accu_frame: RTL and testbench
=============================

Name: accu_frame

Overview:
- Parametrised successor to the fixed 12-beat serial accumulator.
- Sums a programmable number of input beats (1..MAX_N) into a full-width result with no overflow.
- Supports signed or unsigned data, valid/ready backpressure on both sides, and a synchronous frame-abort.
- Sits between a streaming sample source and a downstream consumer; the result register decouples the two with zero-bubble frame turnover.

Parameters:
- DATA_W, 8, input sample width in bits.
- MAX_N, 16, maximum beats per frame (>=2).
- SIGNED, 0, 1 = samples and result are two's complement (sign-extended); 0 = unsigned (zero-extended).
- CNT_W, $clog2(MAX_N+1), derived; width of the frame-length and count fields.
- SUM_W, DATA_W+CNT_W, derived; result width, which guarantees no overflow for any legal frame.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cfg_n  input  CNT_W  beats per frame; sampled only on the first accepted beat of a frame.
- clear  input  1  synchronous abort of the partial frame.
- in_data  input  DATA_W  sample.
- in_valid  input  1  sample valid.
- in_ready  output  1  sample accepted when in_valid && in_ready (combinational).
- out_data  output  SUM_W  frame sum (registered).
- out_valid  output  1  result valid (registered).
- out_ready  input  1  consumer accepts the result when out_valid && out_ready.
- acc_count  output  CNT_W  beats accepted so far in the current partial frame (registered).

Behaviour:
- Reset (async assert, sync release): count=0, sum=0, latched length=0, out_valid=0, out_data=0, acc_count=0.
- Effective length n_eff:
  - cfg_n if 1<=cfg_n<=MAX_N.
  - cfg_n==0 or cfg_n>MAX_N clamps to MAX_N.
  - Latched when count==0 and a beat is accepted; held for the rest of the frame, so later cfg_n changes affect only the next frame.
- Beat acceptance: sum <= sum + ext(in_data), count <= count+1. ext is sign- or zero-extension to SUM_W per SIGNED.
- Final beat (count+1 == n_eff, using the freshly latched value when count==0):
  - out_data <= sum + ext(in_data); out_valid <= 1.
  - count <= 0 and sum <= 0 in the same cycle, so the next frame may start the following cycle with no bubble.
  - Latency: final beat at edge t gives out_valid=1 after edge t.
- Output register: out_valid stays 1 and out_data stays stable until out_valid && out_ready. Acceptance alone clears out_valid on the next edge. A simultaneous acceptance and new final beat keeps out_valid=1 and loads the new sum.
- in_ready = !clear && !(out_valid && !out_ready && next beat would be final). Non-final beats are always accepted, even while a result is pending.
- clear:
  - Zeroes count, sum and acc_count on the next edge.
  - Any beat presented in the same cycle is not accepted (in_ready=0).
  - Does not touch out_valid/out_data; a pending result survives.
- acc_count mirrors count (0..n_eff-1).
- Arithmetic: no saturation or wrap is possible. Maximum magnitude is MAX_N*(2^DATA_W-1), which fits in SUM_W.
- Reset asserted mid-frame or mid-hold discards all state; the pending result is lost.
- States (implicit in count/out_valid):
  - IDLE: count=0.
  - ACCUM: 0<count<n_eff.
  - STALL: final beat pending while out_valid && !out_ready.

Test Plan:
- Unsigned, cfg_n=12, in_valid held high, in_data=1..12, out_ready=1 -> single out_valid pulse one cycle after the 12th beat, out_data=78. The next frame starts the following cycle and acc_count returns to 0.
- cfg_n=1, data 5,6,7 back-to-back, out_ready=1 -> out_valid high for 3 consecutive cycles with out_data 5, 6, 7.
- cfg_n=4, data 255 x4, then out_ready=0 while the next frame feeds 10,20,30,40 -> first result 1020 held stable. in_ready drops on the 4th beat (40) until out_ready=1; the second result is 100.
- SIGNED=1, DATA_W=8, cfg_n=3, data -128, -128, 1 -> out_data = -255 in SUM_W bits (0x301 for SUM_W=10... two's complement of SUM_W width).
- cfg_n=5, 3 beats of 7, then clear with in_valid=1 and in_data=9 -> in_ready=0 that cycle, acc_count=0 after. A new 5 beats of 2 gives 10. A pending earlier result is unaffected.
- cfg_n=0 -> frame of MAX_N beats. cfg_n changed from 4 to 2 mid-frame -> current frame still ends after 4 beats and the next frame uses 2. rst_n pulsed mid-frame -> out_valid=0, acc_count=0 immediately (async).

Source files
------------

// File: rtl/accu_frame_if.sv
// Stream bundle for the frame accumulator: sample input, frame-sum output,
// frame length, abort and progress count.
interface accu_frame_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    localparam int SUM_W = DATA_W + CNT_W;

    logic [CNT_W-1:0]  cfg_n;
    logic              clear;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [SUM_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  acc_count;

    modport master (
        output cfg_n, clear, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, acc_count
    );

    modport slave (
        input  cfg_n, clear, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, acc_count
    );
endinterface

// File: rtl/accu_frame.sv
// Programmable-length frame accumulator: sums 1..MAX_N beats into a full-width
// result held in an output register with valid/ready handoff.
module accu_frame #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    accu_frame_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam int SUM_W = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_N);

    // Widen a sample to the result width; the fill bit is the sample MSB only in signed mode.
    function automatic logic signed [SUM_W-1:0] ext(input logic [DATA_W-1:0] d);
        logic fill;
        fill = SIGNED & d[DATA_W-1];
        return {{CNT_W{fill}}, d};
    endfunction

    logic [CNT_W-1:0]        r_count_p0;
    logic [CNT_W-1:0]        r_len_p0;
    logic signed [SUM_W-1:0] r_sum_p0;
    logic signed [SUM_W-1:0] r_out_data_p1;
    logic                    r_vld_p1;

    logic [CNT_W-1:0]        w_cfg_eff;
    logic [CNT_W-1:0]        w_n_eff;
    logic                    w_last;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_out_take;
    logic signed [SUM_W-1:0] w_sum_next;

    assign w_cfg_eff  = (bus.cfg_n == '0 || bus.cfg_n > MAX_LEN) ? MAX_LEN : bus.cfg_n;
    // The first beat of a frame must see the length it is about to latch.
    assign w_n_eff    = (r_count_p0 == '0) ? w_cfg_eff : r_len_p0;
    assign w_last     = (r_count_p0 + CNT_W'(1)) == w_n_eff;
    assign w_out_take = r_vld_p1 && bus.out_ready;
    assign w_in_ready = !bus.clear && !(r_vld_p1 && !bus.out_ready && w_last);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_sum_next = r_sum_p0 + ext(bus.in_data);

    // Stage p0: running count/sum of the partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_p0 <= '0;
            r_len_p0   <= '0;
            r_sum_p0   <= '0;
        end else if (bus.clear) begin
            r_count_p0 <= '0;
            r_sum_p0   <= '0;
        end else if (w_accept) begin
            if (r_count_p0 == '0) begin
                r_len_p0 <= w_cfg_eff;
            end
            if (w_last) begin
                r_count_p0 <= '0;
                r_sum_p0   <= '0;
            end else begin
                r_count_p0 <= r_count_p0 + CNT_W'(1);
                r_sum_p0   <= w_sum_next;
            end
        end
    end

    // Stage p1: result register, reloaded in the same edge it is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data_p1 <= '0;
            r_vld_p1      <= 1'b0;
        end else if (w_accept && w_last) begin
            r_out_data_p1 <= w_sum_next;
            r_vld_p1      <= 1'b1;
        end else if (w_out_take) begin
            r_vld_p1      <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data_p1;
    assign bus.out_valid = r_vld_p1;
    assign bus.acc_count = r_count_p0;
endmodule

// File: tb/tb_accu_frame.sv
// Directed bench for accu_frame: unsigned instance for most scenarios, a
// signed instance for the sign-extension case.
module tb_accu_frame;
    localparam int DW = 8;
    localparam int MN = 16;
    localparam int CW = 5;
    localparam int SW = DW + CW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    accu_frame_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    accu_frame_if #(.DATA_W(DW), .CNT_W(CW)) bus_s ();

    accu_frame #(.DATA_W(DW), .MAX_N(MN), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    accu_frame #(.DATA_W(DW), .MAX_N(MN), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s.slave)
    );

    task automatic send(input logic [DW-1:0] d);
        bus.in_data = d;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_s(input logic [DW-1:0] d);
        bus_s.in_data = d;
        bus_s.in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.cfg_n = 5'd12; bus.clear = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus_s.cfg_n = 5'd3; bus_s.clear = 1'b0; bus_s.in_data = '0; bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 13'd0) begin n_err++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
        n_cmp++; if (bus.acc_count !== 5'd0) begin n_err++; $display("FAIL reset_acc_count: got %0d want 0", bus.acc_count); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame12();
        bus.cfg_n = 5'd12; bus.out_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            send(DW'(i));
            if (i < 12) begin
                n_cmp++; if (bus.acc_count !== CW'(i)) begin n_err++; $display("FAIL f12_count[%0d]: got %0d want %0d", i, bus.acc_count, i); end
                n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL f12_early_valid[%0d]: got %b want 0", i, bus.out_valid); end
            end
        end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL f12_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 13'd78) begin n_err++; $display("FAIL f12_sum: got %0d want 78", bus.out_data); end
        n_cmp++; if (bus.acc_count !== 5'd0) begin n_err++; $display("FAIL f12_count_wrap: got %0d want 0", bus.acc_count); end
        send(8'd1);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL f12_pulse: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.acc_count !== 5'd1) begin n_err++; $display("FAIL f12_next_start: got %0d want 1", bus.acc_count); end
        bus.in_valid = 1'b0; bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        n_cmp++; if (bus.acc_count !== 5'd0) begin n_err++; $display("FAIL f12_flush: got %0d want 0", bus.acc_count); end
    endtask

    task automatic test_len1();
        logic [DW-1:0] vals [3];
        vals[0] = 8'd5; vals[1] = 8'd6; vals[2] = 8'd7;
        bus.cfg_n = 5'd1; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(vals[i]);
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL len1_valid[%0d]: got %b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.out_data !== SW'(vals[i])) begin n_err++; $display("FAIL len1_data[%0d]: got %0d want %0d", i, bus.out_data, vals[i]); end
        end
        idle();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL len1_drop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.cfg_n = 5'd4; bus.out_ready = 1'b1;
        repeat (4) send(8'd255);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd1020) begin n_err++; $display("FAIL bp_first: got v=%b d=%0d want v=1 d=1020", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b0;
        send(8'd10); send(8'd20); send(8'd30);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd1020) begin n_err++; $display("FAIL bp_hold: got v=%b d=%0d want v=1 d=1020", bus.out_valid, bus.out_data); end
        n_cmp++; if (bus.acc_count !== 5'd3) begin n_err++; $display("FAIL bp_nonfinal_accept: got %0d want 3", bus.acc_count); end
        bus.in_data = 8'd40; bus.in_valid = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_data !== 13'd1020 || bus.acc_count !== 5'd3) begin n_err++; $display("FAIL bp_stalled: got d=%0d cnt=%0d want d=1020 cnt=3", bus.out_data, bus.acc_count); end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd100) begin n_err++; $display("FAIL bp_second: got v=%b d=%0d want v=1 d=100", bus.out_valid, bus.out_data); end
        idle();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_signed();
        send_s(8'h80); send_s(8'h80);
        n_cmp++; if (bus_s.out_valid !== 1'b0) begin n_err++; $display("FAIL signed_early: got %b want 0", bus_s.out_valid); end
        send_s(8'h01);
        bus_s.in_valid = 1'b0;
        n_cmp++; if (bus_s.out_valid !== 1'b1 || bus_s.out_data !== 13'h1F01) begin n_err++; $display("FAIL signed_sum: got v=%b d=%h want v=1 d=1f01", bus_s.out_valid, bus_s.out_data); end
    endtask

    task automatic test_clear();
        bus.cfg_n = 5'd1; bus.out_ready = 1'b0;
        send(8'd3);
        bus.cfg_n = 5'd5;
        repeat (3) send(8'd7);
        n_cmp++; if (bus.acc_count !== 5'd3) begin n_err++; $display("FAIL clr_partial: got %0d want 3", bus.acc_count); end
        bus.clear = 1'b1; bus.in_data = 8'd9; bus.in_valid = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        bus.clear = 1'b0;
        n_cmp++; if (bus.acc_count !== 5'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", bus.acc_count); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd3) begin n_err++; $display("FAIL clr_pending: got v=%b d=%0d want v=1 d=3", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b1;
        repeat (5) send(8'd2);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd10) begin n_err++; $display("FAIL clr_new_frame: got v=%b d=%0d want v=1 d=10", bus.out_valid, bus.out_data); end
        idle();
    endtask

    task automatic test_cfg();
        bus.cfg_n = 5'd0; bus.out_ready = 1'b1;
        repeat (15) send(8'd1);
        n_cmp++; if (bus.acc_count !== 5'd15 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL cfg0_partial: got cnt=%0d v=%b want cnt=15 v=0", bus.acc_count, bus.out_valid); end
        send(8'd1);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd16) begin n_err++; $display("FAIL cfg0_sum: got v=%b d=%0d want v=1 d=16", bus.out_valid, bus.out_data); end
        bus.cfg_n = 5'd20;
        repeat (16) send(8'd255);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd4080) begin n_err++; $display("FAIL cfg_over_max: got v=%b d=%0d want v=1 d=4080", bus.out_valid, bus.out_data); end
        bus.cfg_n = 5'd4;
        send(8'd1);
        bus.cfg_n = 5'd2;
        send(8'd1);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.acc_count !== 5'd2) begin n_err++; $display("FAIL cfg_change_held: got v=%b cnt=%0d want v=0 cnt=2", bus.out_valid, bus.acc_count); end
        send(8'd1); send(8'd1);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd4) begin n_err++; $display("FAIL cfg_old_len: got v=%b d=%0d want v=1 d=4", bus.out_valid, bus.out_data); end
        send(8'd3); send(8'd4);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd7) begin n_err++; $display("FAIL cfg_new_len: got v=%b d=%0d want v=1 d=7", bus.out_valid, bus.out_data); end
        idle();
    endtask

    task automatic test_async_reset();
        bus.cfg_n = 5'd1; bus.out_ready = 1'b0;
        send(8'd9);
        bus.cfg_n = 5'd4;
        send(8'd1); send(8'd1);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.acc_count !== 5'd2) begin n_err++; $display("FAIL arst_setup: got v=%b cnt=%0d want v=1 cnt=2", bus.out_valid, bus.acc_count); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.acc_count !== 5'd0 || bus.out_data !== 13'd0) begin n_err++; $display("FAIL arst_immediate: got v=%b cnt=%0d d=%0d want 0/0/0", bus.out_valid, bus.acc_count, bus.out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.cfg_n = 5'd2; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        send(8'd5); send(8'd6);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd11) begin n_err++; $display("FAIL arst_fresh: got v=%b d=%0d want v=1 d=11", bus.out_valid, bus.out_data); end
        idle();
    endtask

    initial begin
        test_reset();
        test_frame12();
        test_len1();
        test_backpressure();
        test_signed();
        test_clear();
        test_cfg();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish within 100000 time units");
        $fatal(1, "timeout");
    end
endmodule
